team_06_sram_responder: RTL and testbench
=========================================

TEAM_06_SRAM_RESPONDER -- requirements
Module: team_06_sram_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning macro wait cycles after the strobe; legal range 1..7.
REQ-002 SHALL have parameter BASE, default 32'h33000000, meaning the first byte address of the window.
REQ-003 SHALL have port clk  in  1  system clock; the block uses one clock only.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port addressOut  in  32  byte address of the request.
REQ-006 SHALL have port select  in  4  byte-lane write enables.
REQ-007 SHALL have port busAudioWrite  in  32  write data.
REQ-008 SHALL have port write  in  1  write request level.
REQ-009 SHALL have port read  in  1  read request level.
REQ-010 SHALL have port busAudioRead  out  32  read data, valid when busySRAM is low after a read.
REQ-011 SHALL have port busySRAM  out  1  request in progress.
REQ-012 SHALL have port addrError  out  1  sticky out-of-window flag.
REQ-013 SHALL have macro ports: sram_en out 1; sram_we out 1; sram_wmask out 4; sram_addr out 11; sram_din out 32; sram_dout in 32 (1-cycle read latency).

Function
REQ-014 SHALL accept a request only on a rising edge of read or write, using registered copies read_q and write_q. A level held high after completion SHALL NOT re-trigger.
REQ-015 SHALL implement FSM IDLE, ACCESS, WAIT:
- IDLE->ACCESS on an accepted edge.
- ACCESS->WAIT always.
- WAIT->IDLE when the wait counter reaches LATENCY-1.
REQ-016 busySRAM SHALL be combinational: high when (state==IDLE and an accepted edge is present) or state!=IDLE. The initiator therefore sees busy in the same cycle its request rises.
REQ-017 SHALL latch on the IDLE->ACCESS edge:
- word index = addressOut[12:2];
- select;
- busAudioWrite;
- direction.
REQ-018 In ACCESS, SHALL drive for exactly one cycle:
- sram_en=1;
- sram_we=direction;
- sram_wmask=select for writes, 0 for reads;
- sram_addr=latched index;
- sram_din=latched data.
sram_en SHALL be 0 in all other cycles.
REQ-019 Read data: on the final WAIT cycle, SHALL register busAudioRead<=sram_dout. busAudioRead SHALL hold until the next read completes; writes SHALL NOT change it.
REQ-020 Latency: a request rising in cycle N SHALL have busySRAM low from cycle N+2+LATENCY.
REQ-021 Simultaneous rising edges of read and write SHALL service the write first. A pending-read flag SHALL then start the read from IDLE on the next cycle without a new edge.
REQ-022 An edge arriving while not IDLE SHALL be recorded in the pending flag for its direction and serviced on return to IDLE (at most one pending per direction).
REQ-023 Out-of-window address (addressOut-BASE >= 32'h2000 or addressOut<BASE), applied per request:
- no macro strobe;
- a read returns 0;
- full handshake timing kept;
- addrError set to 1 until reset.
REQ-024 Low two address bits SHALL be ignored (word access).
REQ-025 A write with select==4'b0000 SHALL complete normally, with sram_wmask=0.

Reset
REQ-026 On rst SHALL set state=IDLE, wait counter=0, read_q=0, write_q=0, pending flags=0, busAudioRead=0, addrError=0, and macro outputs=0.
REQ-027 rst mid-request SHALL abandon the access; busySRAM SHALL be 0 in the cycle after rst is sampled.

Structure
REQ-028 The FSM state typedef and BASE/window-size constants SHALL live in shared package team_06_pkg.
REQ-029 The edge-detect and pending logic SHALL be one sub-module, team_06_req_tracker.

Verification
REQ-030 Write 0xA1B2C3D4 to 0x33000010 (select=F), then read 0x33000010 -> busAudioRead=0xA1B2C3D4, busy width 2+LATENCY cycles.
REQ-031 Write 0xFFFFFFFF then 0x00000000 with select=4'b0101 to word 4, read -> 0xFF00FF00.
REQ-032 read and write rise in the same cycle -> the write strobe precedes the read strobe, and busy stays high across both.
REQ-033 Read to 0x33002000 -> no sram_en, busAudioRead=0, addrError=1 and sticky.
REQ-034 Hold read high for 10 cycles after completion -> exactly one sram_en pulse.
REQ-035 Assert rst during WAIT -> busySRAM=0 and state IDLE in the next cycle, and addrError=0.

Source files
------------

// File: rtl/team_06_pkg.sv
// team_06_pkg: shared state encoding, address window and request bundle
// for the SRAM responder slice.
package team_06_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_WAIT   = 2'd2;

  localparam logic [31:0] SRAM_BASE = 32'h3300_0000;
  localparam logic [31:0] WIN_SIZE  = 32'h0000_2000;

  typedef struct packed {
    logic        we;
    logic        oob;
    logic [10:0] idx;
    logic [3:0]  sel;
    logic [31:0] data;
  } req_t;

  function automatic logic in_window(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr >= base) &&
           ((addr - base) < WIN_SIZE);
  endfunction

endpackage

// File: rtl/team_06_req_tracker.sv
// team_06_req_tracker: rising-edge detect on read/write levels plus one
// pending slot per direction; writes win when both want to start.
// Ports: clk, rst (sync, active-high), read/write levels, idle from FSM,
//        start_w/start_r one-cycle start grants (only while idle).
module team_06_req_tracker (
  input  logic clk,
  input  logic rst,
  input  logic read,
  input  logic write,
  input  logic idle,
  output logic start_w,
  output logic start_r
);

  logic read_q;
  logic write_q;
  logic pend_r;
  logic pend_w;
  logic rise_r;
  logic rise_w;
  logic want_r;
  logic want_w;

  assign rise_r = read & ~read_q;
  assign rise_w = write & ~write_q;
  assign want_r = rise_r | pend_r;
  assign want_w = rise_w | pend_w;

  assign start_w = idle & want_w;
  assign start_r = idle & ~want_w & want_r;

  // A start consumes one request of its direction; a second one
  // arriving in the same cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      pend_r  <= 1'b0;
      pend_w  <= 1'b0;
    end else begin
      read_q  <= read;
      write_q <= write;
      if (start_w)
        pend_w <= pend_w & rise_w;
      else if (rise_w)
        pend_w <= 1'b1;
      if (start_r)
        pend_r <= pend_r & rise_r;
      else if (rise_r)
        pend_r <= 1'b1;
    end
  end

endmodule

// File: rtl/team_06_sram_responder.sv
// team_06_sram_responder: bus slave mapping a 2K-word window onto a
// 1-cycle-read SRAM macro with LATENCY wait cycles per access.
// Ports: clk, rst (sync, active-high); bus side addressOut, select,
//        busAudioWrite, write, read -> busAudioRead, busySRAM, addrError;
//        macro side sram_en/we/wmask/addr/din, sram_dout.
module team_06_sram_responder
  import team_06_pkg::*;
#(
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = SRAM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addressOut,
  input  logic [3:0]  select,
  input  logic [31:0] busAudioWrite,
  input  logic        write,
  input  logic        read,
  output logic [31:0] busAudioRead,
  output logic        busySRAM,
  output logic        addrError,
  output logic        sram_en,
  output logic        sram_we,
  output logic [3:0]  sram_wmask,
  output logic [10:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  localparam logic [2:0] LAST = 3'(LATENCY - 1);

  state_t     state;
  logic [2:0] cnt;
  req_t       req;
  logic       idle;
  logic       start;
  logic       start_w;
  logic       start_r;
  logic       in_win;
  logic       strobe;

  assign idle   = (state == S_IDLE);
  assign start  = start_w | start_r;
  assign in_win = in_window(addressOut, BASE);

  // Busy rises combinationally with the accepted request.
  assign busySRAM = ~idle | start;

  team_06_req_tracker u_trk (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .idle    (idle),
    .start_w (start_w),
    .start_r (start_r)
  );

  // Out-of-window requests keep their timing but never touch the macro;
  // rst kills a strobe so an abandoned write cannot land.
  assign strobe = (state == S_ACCESS) & ~req.oob & ~rst;

  assign sram_en    = strobe;
  assign sram_we    = strobe & req.we;
  assign sram_wmask = (strobe & req.we) ? req.sel : 4'd0;
  assign sram_addr  = strobe ? req.idx : 11'd0;
  assign sram_din   = strobe ? req.data : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      req          <= '0;
      busAudioRead <= 32'd0;
      addrError    <= 1'b0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (start) begin
            state <= S_ACCESS;
            req   <= '{we:   start_w,
                       oob:  ~in_win,
                       idx:  addressOut[12:2],
                       sel:  select,
                       data: busAudioWrite};
            if (!in_win)
              addrError <= 1'b1;
          end
        end
        state == S_ACCESS: begin
          state <= S_WAIT;
          cnt   <= 3'd0;
        end
        state == S_WAIT: begin
          if (cnt == LAST) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            if (!req.we)
              busAudioRead <= req.oob ? 32'd0 : sram_dout;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_sram_responder.sv
// tb_team_06_sram_responder: directed + random stimulus checked every
// cycle against a request-timeline model of the responder.
module tb_team_06_sram_responder;

  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'h3300_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addressOut;
  logic [3:0]  select;
  logic [31:0] busAudioWrite;
  logic        write;
  logic        read;
  logic [31:0] busAudioRead;
  logic        busySRAM;
  logic        addrError;
  logic        sram_en;
  logic        sram_we;
  logic [3:0]  sram_wmask;
  logic [10:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  always #5 clk = ~clk;

  team_06_sram_responder #(
    .LATENCY (LAT),
    .BASE    (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addressOut    (addressOut),
    .select        (select),
    .busAudioWrite (busAudioWrite),
    .write         (write),
    .read          (read),
    .busAudioRead  (busAudioRead),
    .busySRAM      (busySRAM),
    .addrError     (addrError),
    .sram_en       (sram_en),
    .sram_we       (sram_we),
    .sram_wmask    (sram_wmask),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  int total = 0;
  int bad   = 0;
  bit mem_clr;

  function automatic void chk(input string n,
                              input logic [31:0] a,
                              input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", n, $time, a, e);
    end
  endfunction

  // SRAM macro: one-cycle registered read, byte-masked write, dout holds.
  logic [31:0] mac [2048];
  logic [31:0] mac_dout;
  assign sram_dout = mac_dout;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mac[i] <= 32'd0;
      mac_dout <= 32'd0;
    end else if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mac[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        mac_dout <= mac[sram_addr];
      end
    end
  end

  // Reference model: each job spans cycles 0..LAT+1 from its start
  // cycle; strobe in cycle 1; completion effects at the end of LAT+1.
  logic [31:0] ref_mem [2048];
  bit          m_prev_r, m_prev_w, m_pend_r, m_pend_w, m_act;
  int          m_age, nw, nr;
  bit          m_we, m_oob, rise_r, rise_w, en_e;
  logic [10:0] m_idx;
  logic [3:0]  m_sel;
  logic [31:0] m_dat, m_rd;
  bit          m_err;
  int          pulses = 0;
  bit          slog[$];

  always @(negedge clk) begin
    if (mem_clr)
      for (int i = 0; i < 2048; i++) ref_mem[i] = 32'd0;
    if (rst) begin
      m_prev_r = 0; m_prev_w = 0; m_pend_r = 0; m_pend_w = 0;
      m_act = 0; m_age = 0; m_rd = 32'd0; m_err = 0;
    end else begin
      rise_r = read && !m_prev_r;
      rise_w = write && !m_prev_w;
      if (!m_act) begin
        nw = int'(m_pend_w) + int'(rise_w);
        nr = int'(m_pend_r) + int'(rise_r);
        if (nw > 0) begin m_act = 1; m_we = 1; nw--; end
        else if (nr > 0) begin m_act = 1; m_we = 0; nr--; end
        if (m_act) begin
          m_age = 0;
          m_idx = addressOut[12:2];
          m_sel = select;
          m_dat = busAudioWrite;
          m_oob = (longint'(addressOut) < longint'(BASE)) ||
                  (longint'(addressOut) >= longint'(BASE) + 64'h2000);
        end
        m_pend_w = nw > 0;
        m_pend_r = nr > 0;
      end else begin
        if (rise_w) m_pend_w = 1;
        if (rise_r) m_pend_r = 1;
      end

      en_e = m_act && m_age == 1 && !m_oob;
      chk("busySRAM", busySRAM, m_act);
      chk("sram_en", sram_en, en_e);
      if (en_e) begin
        chk("sram_we", sram_we, m_we);
        chk("sram_wmask", sram_wmask, m_we ? m_sel : 4'd0);
        chk("sram_addr", sram_addr, m_idx);
        chk("sram_din", sram_din, m_dat);
      end
      chk("busAudioRead", busAudioRead, m_rd);
      chk("addrError", addrError, m_err);
      if (sram_en) begin
        pulses++;
        slog.push_back(sram_we);
      end

      if (m_act) begin
        if (m_age == 0 && m_oob) m_err = 1;
        if (m_age == 1 && m_we && !m_oob)
          for (int b = 0; b < 4; b++)
            if (m_sel[b]) ref_mem[m_idx][8*b +: 8] = m_dat[8*b +: 8];
        if (m_age == LAT + 1) begin
          if (!m_we) m_rd = m_oob ? 32'd0 : ref_mem[m_idx];
          m_act = 0;
        end else begin
          m_age++;
        end
      end
      m_prev_r = read;
      m_prev_w = write;
    end
  end

  task automatic wait_idle(output int w);
    w = 0;
    @(negedge clk);
    while (busySRAM === 1'b1 && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL busy_timeout @%0t: got busy after %0d want idle", $time, w);
    end
  endtask

  task automatic do_req(input bit w,
                        input logic [31:0] a,
                        input logic [3:0] s,
                        input logic [31:0] d,
                        output int width);
    @(posedge clk); #1;
    addressOut = a;
    select = s;
    busAudioWrite = d;
    if (w) write = 1'b1;
    else read = 1'b1;
    wait_idle(width);
    @(posedge clk); #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wd;
    int p0;
    int r;
    rst = 1'b1; mem_clr = 1'b1;
    read = 1'b0; write = 1'b0;
    addressOut = BASE; select = 4'd0; busAudioWrite = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", busySRAM, 1'b0);
    chk("rst_rdata", busAudioRead, 32'd0);
    chk("rst_err", addrError, 1'b0);
    chk("rst_en", sram_en, 1'b0);

    do_req(1, BASE + 32'h10, 4'hF, 32'hA1B2_C3D4, wd);
    chk("wr_width", wd, 2 + LAT);
    do_req(0, BASE + 32'h10, 4'hF, 32'd0, wd);
    chk("rd_width", wd, 2 + LAT);
    chk("rd_data", busAudioRead, 32'hA1B2_C3D4);

    do_req(1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, wd);
    do_req(1, BASE + 32'h13, 4'b0101, 32'h0000_0000, wd);
    do_req(0, BASE + 32'h11, 4'hF, 32'd0, wd);
    chk("mask_data", busAudioRead, 32'hFF00_FF00);

    @(posedge clk); #1;
    addressOut = BASE + 32'h20; select = 4'hF;
    busAudioWrite = 32'h1234_5678;
    slog.delete();
    read = 1'b1; write = 1'b1;
    wait_idle(wd);
    chk("dual_width", wd, 2 * (2 + LAT));
    chk("dual_strobes", slog.size(), 2);
    if (slog.size() == 2) begin
      chk("dual_first_we", slog[0], 1'b1);
      chk("dual_second_we", slog[1], 1'b0);
    end
    chk("dual_data", busAudioRead, 32'h1234_5678);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;

    @(posedge clk); #1;
    addressOut = BASE + 32'h10;
    p0 = pulses;
    read = 1'b1;
    repeat (2 + LAT + 10) @(negedge clk);
    chk("hold_pulses", pulses - p0, 1);
    chk("hold_data", busAudioRead, 32'hFF00_FF00);
    @(posedge clk); #1;
    read = 1'b0;

    p0 = pulses;
    do_req(0, BASE + 32'h2000, 4'hF, 32'd0, wd);
    chk("oob_width", wd, 2 + LAT);
    chk("oob_pulses", pulses - p0, 0);
    chk("oob_data", busAudioRead, 32'd0);
    chk("oob_err", addrError, 1'b1);
    do_req(1, BASE + 32'h40, 4'hF, 32'h5555_AAAA, wd);
    chk("oob_sticky", addrError, 1'b1);

    @(posedge clk); #1;
    addressOut = BASE + 32'h40;
    read = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busySRAM, 1'b0);
    chk("mid_rst_err", addrError, 1'b0);
    chk("mid_rst_rdata", busAudioRead, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) read = ~read;
      if ($urandom_range(0, 3) == 0) write = ~write;
      r = int'($urandom_range(0, 19));
      if (r == 0)
        addressOut = BASE + 32'h2000 + $urandom_range(0, 255);
      else if (r == 1)
        addressOut = BASE - $urandom_range(1, 64);
      else
        addressOut = BASE + $urandom_range(0, 63);
      select = 4'($urandom);
      busAudioWrite = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0; read = 1'b0; write = 1'b0;
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
